// File: rtl/turf_wb_byte_bridge_pkg.sv
// Shared types and constants for the byte-stream to WISHBONE bridge.
package turf_wb_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StBus,
    StRstat,
    StRdata
  } state_e;

  localparam logic [7:0] STATUS_ACK     = 8'h00;
  localparam logic [7:0] STATUS_ERR     = 8'h01;
  localparam logic [7:0] STATUS_RTY     = 8'h02;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h03;

  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam int unsigned CMD_SEL_MSB   = 3;
  localparam int unsigned CMD_SEL_LSB   = 0;

endpackage

// File: rtl/turf_wb_byte_bridge_if.sv
// Command/response byte streams plus the WISHBONE initiator port of the bridge.
interface turf_wb_byte_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [7:0]              s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic [7:0]              m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    wb_rty_i;

  // Bridge side.
  modport master (
    input  s_tdata, s_tvalid, m_tready, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output s_tready, m_tdata, m_tvalid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
           wb_sel_o
  );

  // Environment side: command source, response sink and WISHBONE target.
  modport slave (
    output s_tdata, s_tvalid, m_tready, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  s_tready, m_tdata, m_tvalid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
           wb_sel_o
  );
endinterface

// File: rtl/turf_wb_byte_bridge.sv
// Parses CMD/ADDR/WDATA byte packets, runs one classic WISHBONE cycle per packet and
// returns a status byte (plus read data on an acked read).
module turf_wb_byte_bridge
  import turf_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  turf_wb_byte_bridge_if.master bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  logic                    s_tready_q;
  logic                    m_tvalid_q;
  logic [7:0]              m_tdata_q;
  logic                    cyc_q;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   wdat_q;
  logic [DATA_WIDTH-1:0]   rdat_q;
  logic [7:0]              status_q;
  logic [1:0]              cnt_q;
  logic [TmoW-1:0]         tmo_q;

  logic s_hs;
  logic m_hs;

  assign s_hs = bus.s_tvalid & s_tready_q;
  assign m_hs = m_tvalid_q & bus.m_tready;

  assign bus.s_tready = s_tready_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_sel_o = sel_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = wdat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 8'h00;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      status_q   <= STATUS_ACK;
      cnt_q      <= 2'd0;
      tmo_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          s_tready_q <= 1'b1;
          if (s_hs) begin
            we_q    <= bus.s_tdata[CMD_WRITE_BIT];
            sel_q   <= bus.s_tdata[CMD_SEL_MSB:CMD_SEL_LSB];
            cnt_q   <= 2'd0;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (s_hs) begin
            // Shifting into a 28-bit register drops the upper nibble of the 32-bit field.
            adr_q <= {adr_q[ADDR_WIDTH-9:0], bus.s_tdata};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (we_q) begin
                state_q <= StWdata;
              end else begin
                state_q    <= StBus;
                s_tready_q <= 1'b0;
                cyc_q      <= 1'b1;
                tmo_q      <= '0;
              end
            end
          end
        end
        StWdata: begin
          if (s_hs) begin
            wdat_q <= {wdat_q[DATA_WIDTH-9:0], bus.s_tdata};
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q    <= StBus;
              s_tready_q <= 1'b0;
              cyc_q      <= 1'b1;
              tmo_q      <= '0;
            end
          end
        end
        StBus: begin
          if (bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i || (tmo_q == TmoLast)) begin
            cyc_q      <= 1'b0;
            m_tvalid_q <= 1'b1;
            state_q    <= StRstat;
            if (bus.wb_ack_i) begin
              status_q  <= STATUS_ACK;
              m_tdata_q <= STATUS_ACK;
              if (!we_q) rdat_q <= bus.wb_dat_i;
            end else if (bus.wb_err_i) begin
              status_q  <= STATUS_ERR;
              m_tdata_q <= STATUS_ERR;
            end else if (bus.wb_rty_i) begin
              status_q  <= STATUS_RTY;
              m_tdata_q <= STATUS_RTY;
            end else begin
              status_q  <= STATUS_TIMEOUT;
              m_tdata_q <= STATUS_TIMEOUT;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StRstat: begin
          if (m_hs) begin
            if (!we_q && (status_q == STATUS_ACK)) begin
              m_tdata_q <= rdat_q[DATA_WIDTH-1 -: 8];
              rdat_q    <= {rdat_q[DATA_WIDTH-9:0], 8'h00};
              cnt_q     <= 2'd0;
              state_q   <= StRdata;
            end else begin
              m_tvalid_q <= 1'b0;
              s_tready_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
        end
        StRdata: begin
          if (m_hs) begin
            if (cnt_q == 2'd3) begin
              m_tvalid_q <= 1'b0;
              s_tready_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              m_tdata_q <= rdat_q[DATA_WIDTH-1 -: 8];
              rdat_q    <= {rdat_q[DATA_WIDTH-9:0], 8'h00};
              cnt_q     <= cnt_q + 2'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_turf_wb_byte_bridge.sv
// Directed plus randomized transactions against a packet-level model of the bridge.
module tb_turf_wb_byte_bridge;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  turf_wb_byte_bridge_if #(.ADDR_WIDTH(28), .DATA_WIDTH(32)) bif ();

  turf_wb_byte_bridge #(
    .TIMEOUT_CYCLES(TMO),
    .ADDR_WIDTH    (28),
    .DATA_WIDTH    (32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte's handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bif.s_tdata  = b;
    bif.s_tvalid = 1'b1;
    while (bif.s_tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("s_tready_wait", {63'd0, bif.s_tready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic we, input logic [2:0] junk, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
    send_byte({we, junk, sel});
    for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
    if (we) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
    bif.s_tvalid = 1'b0;
  endtask

  // kind = {rty, err, ack} asserted together after delay cycles; 0 means the target never answers.
  task automatic do_txn(input logic we, input logic [2:0] junk, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] kind,
                        input int delay, input logic [31:0] rdat, input int bp);
    logic [7:0] expq[$];
    logic [7:0] st;
    int         hi;
    int         exp_hi;
    int         n;
    st = kind[0] ? 8'h00 : kind[1] ? 8'h01 : kind[2] ? 8'h02 : 8'h03;
    expq = {st};
    if (!we && kind[0]) for (int i = 3; i >= 0; i--) expq.push_back(rdat[i*8 +: 8]);
    exp_hi = (kind == 3'b000) ? TMO : delay + 1;

    send_pkt(we, junk, sel, adr, dat);
    chk("cyc_start", {63'd0, bif.wb_cyc_o}, 64'd1);
    hi = 0;
    while (bif.wb_cyc_o === 1'b1 && hi < 64) begin
      chk("bus_ctl", {30'd0, bif.wb_stb_o, bif.wb_we_o, bif.wb_sel_o, bif.wb_adr_o},
          {30'd0, 1'b1, we, sel, adr[27:0]});
      if (we) chk("bus_wdat", {32'd0, bif.wb_dat_o}, {32'd0, dat});
      chk("s_tready_bus", {63'd0, bif.s_tready}, 64'd0);
      hi++;
      if (kind != 3'b000 && hi == delay + 1) begin
        bif.wb_ack_i = kind[0];
        bif.wb_err_i = kind[1];
        bif.wb_rty_i = kind[2];
        bif.wb_dat_i = (!we && kind[0]) ? rdat : $urandom;
      end
      @(negedge clk);
      bif.wb_ack_i = 1'b0;
      bif.wb_err_i = 1'b0;
      bif.wb_rty_i = 1'b0;
      bif.wb_dat_i = $urandom;
    end
    chk("cyc_cycles", 64'(hi), 64'(exp_hi));
    chk("stb_drop", {63'd0, bif.wb_stb_o}, 64'd0);

    foreach (expq[i]) begin
      n = 0;
      while (bif.m_tvalid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("m_tvalid", {63'd0, bif.m_tvalid}, 64'd1);
      for (int k = 0; k < bp; k++) begin
        bif.s_tvalid = 1'($urandom);
        bif.s_tdata  = 8'($urandom);
        bif.wb_ack_i = 1'($urandom);  // late terminations must be ignored
        @(negedge clk);
        chk("bp_hold", {55'd0, bif.m_tvalid, bif.m_tdata}, {55'd0, 1'b1, expq[i]});
        chk("bp_s_tready", {63'd0, bif.s_tready}, 64'd0);
      end
      bif.s_tvalid = 1'b0;
      bif.wb_ack_i = 1'b0;
      chk("resp_byte", {56'd0, bif.m_tdata}, {56'd0, expq[i]});
      bif.m_tready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bif.m_tready = 1'b0;
    end
    chk("resp_done", {62'd0, bif.m_tvalid, bif.s_tready}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  kind;
    bif.s_tdata  = 8'h00;
    bif.s_tvalid = 1'b0;
    bif.m_tready = 1'b0;
    bif.wb_dat_i = 32'h0;
    bif.wb_ack_i = 1'b0;
    bif.wb_err_i = 1'b0;
    bif.wb_rty_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {59'd0, bif.s_tready, bif.m_tvalid, bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o},
        64'd0);
    chk("rst_adr_sel", {32'd0, bif.wb_adr_o, bif.wb_sel_o}, 64'd0);
    chk("rst_dat", {24'd0, bif.wb_dat_o, bif.m_tdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {63'd0, bif.s_tready}, 64'd1);

    // Directed plan.
    do_txn(1'b1, 3'b000, 4'hF, 32'h0001_8004, 32'hDEAD_BEEF, 3'b001, 2, 32'h0, 0);
    do_txn(1'b0, 3'b000, 4'h3, 32'hF000_8000, 32'h0, 3'b001, 1, 32'h1234_5678, 0);
    do_txn(1'b0, 3'b000, 4'hA, 32'h0000_0100, 32'h0, 3'b110, 0, 32'hCAFE_F00D, 0);
    do_txn(1'b0, 3'b000, 4'hA, 32'h0000_0100, 32'h0, 3'b011, 0, 32'hCAFE_F00D, 0);
    do_txn(1'b0, 3'b000, 4'h1, 32'h0ABC_DEF0, 32'h0, 3'b000, 0, 32'h0, 0);
    do_txn(1'b0, 3'b101, 4'hC, 32'h0765_4321, 32'h0, 3'b001, 4, 32'hA1B2_C3D4, 5);

    // Reset while the cycle is in flight: no response may follow.
    send_pkt(1'b0, 3'b000, 4'hF, 32'h0000_0040, 32'h0);
    repeat (2) @(negedge clk);
    chk("mid_bus_cyc", {63'd0, bif.wb_cyc_o}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_bus_drop", {61'd0, bif.wb_cyc_o, bif.wb_stb_o, bif.m_tvalid}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", {63'd0, bif.m_tvalid}, 64'd0);
    end
    do_txn(1'b1, 3'b000, 4'hF, 32'h0, 32'h0000_0001, 3'b001, 0, 32'h0, 0);

    // Reset mid-packet discards the partial bytes.
    send_byte(8'h8F);
    send_byte(8'h11);
    send_byte(8'h22);
    bif.s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pkt_idle", {62'd0, bif.s_tready, bif.wb_cyc_o}, 64'd2);
    do_txn(1'b0, 3'b000, 4'h5, 32'h0333_4444, 32'h0, 3'b001, 1, 32'h5566_7788, 1);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      ra   = $urandom;
      kind = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      do_txn(1'($urandom), 3'($urandom), 4'($urandom), ra, $urandom, kind,
             $urandom_range(0, 6), $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
